// File: rtl/myproject_mul_pipe_sat.sv
// rtl/myproject_mul_pipe_sat.sv - pipelined signed multiply with round, shift and saturate
module myproject_mul_pipe_sat #(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 13,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 2,
    parameter int SHIFT       = 0,
    parameter int ROUND       = 0,
    parameter int DOUT_WIDTH  = 28
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic        [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf,
    input  logic                         ovf_clr
);

    // Product width plus one guard bit so the rounding add can never wrap.
    localparam int EW = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam logic [EW-1:0] RND_ADD =
        (ROUND != 0 && SHIFT > 0) ? (EW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic signed [DIN1_WIDTH:0]   din1_ext;
    logic signed [EW-1:0]         prod;
    logic signed [EW-1:0]         rnd;
    logic signed [EW-1:0]         shifted;
    logic signed [DOUT_WIDTH-1:0] res;
    logic                         res_sat;
    logic                         advance;
    logic                         enter_sat;

    logic [NUM_STAGE-1:0]         stg_vld;
    logic [NUM_STAGE-1:0]         stg_sat;
    logic signed [DOUT_WIDTH-1:0] stg_data [NUM_STAGE];

    // An extra top bit lets one signed multiplier serve both din1 signedness modes.
    assign din1_ext = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
    assign prod     = din0 * din1_ext;
    assign rnd      = prod + $signed(RND_ADD);
    assign shifted  = rnd >>> SHIFT;

    generate
        if (DOUT_WIDTH >= EW) begin : g_wide
            assign res     = DOUT_WIDTH'(shifted);
            assign res_sat = 1'b0;
        end else begin : g_sat
            // Value fits only when all bits from the output sign bit upward agree.
            logic [EW-DOUT_WIDTH:0] top;
            assign top     = shifted[EW-1:DOUT_WIDTH-1];
            assign res_sat = !((&top) || !(|top));
            assign res     = !res_sat ? shifted[DOUT_WIDTH-1:0] :
                             shifted[EW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} :
                                             {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end

        // Saturation flag of whatever moves into the output stage on an advance.
        if (NUM_STAGE == 1) begin : g_enter1
            assign enter_sat = in_valid & res_sat;
        end else begin : g_entern
            assign enter_sat = stg_sat[NUM_STAGE-2];
        end
    endgenerate

    assign out_valid = stg_vld[NUM_STAGE-1];
    assign dout      = stg_data[NUM_STAGE-1];
    assign advance   = !out_valid | out_ready;
    assign in_ready  = advance;

    // Single-stall pipeline: every stage moves together or everything holds.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stg_vld <= '0;
            stg_sat <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                stg_data[i] <= '0;
            end
        end else if (advance) begin
            stg_vld[0]  <= in_valid;
            stg_sat[0]  <= in_valid & res_sat;
            stg_data[0] <= res;
            for (int i = 1; i < NUM_STAGE; i++) begin
                stg_vld[i]  <= stg_vld[i-1];
                stg_sat[i]  <= stg_sat[i-1];
                stg_data[i] <= stg_data[i-1];
            end
        end
    end

    // Sticky overflow; a new saturated result wins over a same-cycle clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf <= 1'b0;
        end else if (advance && enter_sat) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_myproject_mul_pipe_sat.sv
// tb/tb_myproject_mul_pipe_sat.sv - directed table-driven bench for myproject_mul_pipe_sat
module tb_myproject_mul_pipe_sat;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] din0;
    logic        [12:0] din1;
    logic               out_ready;
    logic               ovf_clr;

    logic               in_ready_def, out_valid_def, ovf_def;
    logic signed [27:0] dout_def;
    logic               in_ready_r1, out_valid_r1, ovf_r1;
    logic signed [27:0] dout_r1;
    logic               in_ready_r0, out_valid_r0, ovf_r0;
    logic signed [27:0] dout_r0;
    logic               in_ready_s16, out_valid_s16, ovf_s16;
    logic signed [15:0] dout_s16;
    logic               in_ready_ns3, out_valid_ns3, ovf_ns3;
    logic signed [27:0] dout_ns3;
    logic               in_ready_sg, out_valid_sg, ovf_sg;
    logic signed [27:0] dout_sg;

    int checks   = 0;
    int failures = 0;

    myproject_mul_pipe_sat u_def (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_def),
        .din0(din0), .din1(din1), .out_valid(out_valid_def), .out_ready(out_ready),
        .dout(dout_def), .ovf(ovf_def), .ovf_clr(ovf_clr));

    myproject_mul_pipe_sat #(.SHIFT(4), .ROUND(1)) u_r1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r1),
        .din0(din0), .din1(din1), .out_valid(out_valid_r1), .out_ready(out_ready),
        .dout(dout_r1), .ovf(ovf_r1), .ovf_clr(ovf_clr));

    myproject_mul_pipe_sat #(.SHIFT(4), .ROUND(0)) u_r0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r0),
        .din0(din0), .din1(din1), .out_valid(out_valid_r0), .out_ready(out_ready),
        .dout(dout_r0), .ovf(ovf_r0), .ovf_clr(ovf_clr));

    myproject_mul_pipe_sat #(.SHIFT(0), .DOUT_WIDTH(16)) u_s16 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s16),
        .din0(din0), .din1(din1), .out_valid(out_valid_s16), .out_ready(out_ready),
        .dout(dout_s16), .ovf(ovf_s16), .ovf_clr(ovf_clr));

    myproject_mul_pipe_sat #(.NUM_STAGE(3)) u_ns3 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_ns3),
        .din0(din0), .din1(din1), .out_valid(out_valid_ns3), .out_ready(out_ready),
        .dout(dout_ns3), .ovf(ovf_ns3), .ovf_clr(ovf_clr));

    myproject_mul_pipe_sat #(.DIN1_SIGNED(1)) u_sg (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_sg),
        .din0(din0), .din1(din1), .out_valid(out_valid_sg), .out_ready(out_ready),
        .dout(dout_sg), .ovf(ovf_sg), .ovf_clr(ovf_clr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int d0;
        int d1;
        int e_def;
        int e_r1;
        int e_r0;
        int e_s16;
        int e_sg;
        int o_def;
        int o_s16;
        int o_sg;
    } vec_t;

    vec_t tbl [9];
    int   q [$];

    initial begin
        int sent;
        int recv;
        int cyc;
        int exp_v;

        tbl[0] = '{-3,     8191, -24573,     -1536,     -1536,     -24573, 3,           0, 0, 0};
        tbl[1] = '{25,     1,    25,         2,         1,         25,     25,          0, 0, 0};
        tbl[2] = '{-24,    1,    -24,        -1,        -2,        -24,    -24,         0, 0, 0};
        tbl[3] = '{32767,  8191, 134217727,  16774656,  16774656,  32767,  -32767,      1, 1, 0};
        tbl[4] = '{-32768, 8191, -134217728, -16775168, -16775168, -32768, 32768,       1, 1, 0};
        tbl[5] = '{-5,     8188, -40940,     -2559,     -2559,     -32768, 20,          0, 1, 0};
        tbl[6] = '{0,      0,    0,          0,         0,         0,      0,           0, 0, 0};
        tbl[7] = '{-32768, 4096, -134217728, -8388608,  -8388608,  -32768, 134217727,   0, 1, 1};
        tbl[8] = '{32767,  4096, 134213632,  8388352,   8388352,   32767,  -134213632,  0, 1, 0};

        // Reset state, with an operand already presented during reset.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        din0      = 16'sd7;
        din1      = 13'd3;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready_def), 1);
        chk("rst_out_valid", int'(out_valid_def), 0);
        chk("rst_dout", int'(dout_def), 0);
        chk("rst_ovf", int'(ovf_def), 0);

        // First transfer on the first rising edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("first_lat1_valid", int'(out_valid_def), 0);
        @(negedge clk);
        chk("first_valid", int'(out_valid_def), 1);
        chk("first_dout", int'(dout_def), 21);
        @(negedge clk);
        chk("first_drain", int'(out_valid_def), 0);

        // Table vectors, one isolated transfer each.
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr  = 1'b0;
            din0     = 16'(tbl[v].d0);
            din1     = 13'(tbl[v].d1);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1_valid", v), int'(out_valid_def), 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", v), int'(out_valid_def), 1);
            chk($sformatf("v%0d_dout_def", v), int'(dout_def), tbl[v].e_def);
            chk($sformatf("v%0d_dout_r1", v), int'(dout_r1), tbl[v].e_r1);
            chk($sformatf("v%0d_dout_r0", v), int'(dout_r0), tbl[v].e_r0);
            chk($sformatf("v%0d_dout_s16", v), int'(dout_s16), tbl[v].e_s16);
            chk($sformatf("v%0d_dout_sg", v), int'(dout_sg), tbl[v].e_sg);
            chk($sformatf("v%0d_ovf_def", v), int'(ovf_def), tbl[v].o_def);
            chk($sformatf("v%0d_ovf_s16", v), int'(ovf_s16), tbl[v].o_s16);
            chk($sformatf("v%0d_ovf_sg", v), int'(ovf_sg), tbl[v].o_sg);
        end

        // Sticky ovf, then clear, then set and clear in the same cycle.
        @(negedge clk);
        chk("ovf_sticky", int'(ovf_s16), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf_s16), 0);
        ovf_clr  = 1'b1;
        din0     = 16'sd32767;
        din1     = 13'd8191;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", int'(ovf_s16), 1);
        chk("ovf_set_wins_dout", int'(dout_s16), 32767);
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Ten back-to-back pairs with a three-cycle output stall.
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 10 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 7);
            if (sent < 10) begin
                in_valid = 1'b1;
                din0     = 16'(sent * 1000 - 4000);
                din1     = 13'(sent * 37 + 5);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid_def) begin
                if (q.size() == 0) begin
                    chk("stream_unexpected_out", 1, 0);
                end else if (out_ready) begin
                    exp_v = q.pop_front();
                    chk($sformatf("stream_dout%0d", recv), int'(dout_def), exp_v);
                    recv++;
                end else begin
                    chk($sformatf("stall_in_ready_c%0d", cyc), int'(in_ready_def), 0);
                    chk($sformatf("stall_dout_c%0d", cyc), int'(dout_def), q[0]);
                end
            end
            if (in_valid && in_ready_def) begin
                q.push_back((sent * 1000 - 4000) * (sent * 37 + 5));
                sent++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", recv, 10);
        repeat (4) @(negedge clk);

        // Three-stage latency with a saturating operand pair.
        @(negedge clk);
        din0     = 16'sd32767;
        din1     = 13'd8191;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ns3_lat1", int'(out_valid_ns3), 0);
        @(negedge clk);
        chk("ns3_lat2", int'(out_valid_ns3), 0);
        @(negedge clk);
        chk("ns3_lat3", int'(out_valid_ns3), 1);
        chk("ns3_dout", int'(dout_ns3), 134217727);
        chk("ns3_ovf", int'(ovf_ns3), 1);

        // Mid-flight asynchronous reset discards every in-flight result.
        @(negedge clk);
        in_valid = 1'b1;
        din0     = 16'sd100;
        din1     = 13'd3;
        @(negedge clk);
        din0 = 16'sd200;
        @(negedge clk);
        din0 = 16'sd300;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ns3_pre_rst_valid", int'(out_valid_ns3), 1);
        chk("ns3_pre_rst_dout", int'(dout_ns3), 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ns3_rst_valid", int'(out_valid_ns3), 0);
        chk("ns3_rst_dout", int'(dout_ns3), 0);
        chk("ns3_rst_ovf", int'(ovf_ns3), 0);
        chk("ns3_rst_in_ready", int'(in_ready_ns3), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("ns3_no_stale%0d", k), int'(out_valid_ns3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
